// File: rtl/vga_fill_ctrl.sv
// Rectangle-fill engine and write-port arbiter for the 160x120 4bpp framebuffer.
// CPU stores always own the write port; the fill engine paints one word per
// idle cycle. All write-port outputs are registered, one cycle after the request.
module vga_fill_ctrl #(
  parameter int unsigned ROWS  = 120,
  parameter int unsigned WCOLS = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_cpuAddr,
  input  logic [31:0] i_cpuData,
  input  logic        i_cpuMemWrite,
  input  logic [1:0]  i_cpuSize,
  input  logic        en_MEM,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [6:0]  i_row0,
  input  logic [6:0]  i_row1,
  input  logic [4:0]  i_wcol0,
  input  logic [4:0]  i_wcol1,
  input  logic [3:0]  i_color,
  output logic [31:0] o_pxlAddr,
  output logic [31:0] o_pxlData,
  output logic        o_memWrite,
  output logic [1:0]  o_size,
  output logic        o_en,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [8:0]  o_words
);

  localparam logic [7:0] ROWS_L  = ROWS[7:0];
  localparam logic [5:0] WCOLS_L = WCOLS[5:0];

  typedef enum logic {IDLE, FILL} state_t;

  state_t      state_q, state_d;
  logic [6:0]  row_q, row_d;
  logic [4:0]  wcol_q, wcol_d;
  logic [6:0]  row1_q, row1_d;
  logic [4:0]  wcol0_q, wcol0_d;
  logic [4:0]  wcol1_q, wcol1_d;
  logic [31:0] color_q, color_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [8:0]  words_q, words_d;

  logic cpu_we;
  logic cmd_ok;
  logic last_word;

  assign cpu_we    = i_cpuMemWrite & en_MEM;
  assign cmd_ok    = (i_row0 <= i_row1) && ({1'b0, i_row1} < ROWS_L) &&
                     (i_wcol0 <= i_wcol1) && ({1'b0, i_wcol1} < WCOLS_L);
  assign last_word = (row_q == row1_q) && (wcol_q == wcol1_q);

  // State and datapath registers; reset clears every output and counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      wcol_q  <= '0;
      row1_q  <= '0;
      wcol0_q <= '0;
      wcol1_q <= '0;
      color_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wcol_q  <= wcol_d;
      row1_q  <= row1_d;
      wcol0_q <= wcol0_d;
      wcol1_q <= wcol1_d;
      color_q <= color_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  // Next-state: CPU store wins the port; fill issues a word only on idle cycles.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    wcol_d  = wcol_q;
    row1_d  = row1_q;
    wcol0_d = wcol0_q;
    wcol1_d = wcol1_q;
    color_d = color_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    words_d = words_q;

    if (cpu_we) begin
      addr_d = i_cpuAddr;
      data_d = i_cpuData;
      size_d = i_cpuSize;
      we_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (cmd_ok) begin
            row_d   = i_row0;
            wcol_d  = i_wcol0;
            row1_d  = i_row1;
            wcol0_d = i_wcol0;
            wcol1_d = i_wcol1;
            color_d = {8{i_color}};
            words_d = '0;
            state_d = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL: begin
        if (i_abort) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (!cpu_we) begin
          addr_d  = {17'b0, row_q, 1'b0, wcol_q, 2'b00};
          data_d  = color_q;
          size_d  = 2'b10;
          we_d    = 1'b1;
          words_d = (words_q == '1) ? words_q : words_q + 9'd1;
          if (wcol_q == wcol1_q) begin
            wcol_d = wcol0_q;
            row_d  = row_q + 7'd1;
          end else begin
            wcol_d = wcol_q + 5'd1;
          end
          if (last_word) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_pxlAddr  = addr_q;
  assign o_pxlData  = data_q;
  assign o_memWrite = we_q;
  assign o_size     = size_q;
  assign o_en       = we_q;
  assign o_busy     = (state_q == FILL);
  assign o_done     = done_q;
  assign o_err      = err_q;
  assign o_words    = words_q;

endmodule
